// File: rtl/video_timing_720p_pkg.sv
// Shared timing constants for the 720p60 raster generator.
// Contents:
//   H_*/V_* : CEA-861 720p60 porch, sync and active widths, plus line/frame totals
//   X_W/Y_W : widths of the pixel column/line coordinates
//   HSYNC/VSYNC : bit positions inside the 2-bit sync bus
//   sync_idle() : level of the sync bus while no sync pulse is asserted
package hdmi_720p_timing_pkg;

  localparam int H_ACTIVE = 1280;
  localparam int H_FP     = 110;
  localparam int H_SYNC   = 40;
  localparam int H_BP     = 220;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;  // 1650

  localparam int V_ACTIVE = 720;
  localparam int V_FP     = 5;
  localparam int V_SYNC   = 5;
  localparam int V_BP     = 20;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;  // 750

  localparam int X_W = 11;
  localparam int Y_W = 10;

  localparam int HSYNC = 0;
  localparam int VSYNC = 1;

  typedef logic [X_W-1:0] x_t;
  typedef logic [Y_W-1:0] y_t;

  // Both sync bits idle low for active-high polarity, high otherwise.
  function automatic logic [1:0] sync_idle(input bit active_high);
    return active_high ? 2'b00 : 2'b11;
  endfunction

endpackage

// File: rtl/video_timing_720p_if.sv
// Request/encoder-side bundle of the raster timing generator.
// Signals:
//   requestValid/requestX/requestY : pixel to fetch this cycle (coordinates 0 when not valid)
//   frameStart / lineStart         : one-cycle pulses with the request of (0,0) / (0,y)
//   blank / sync                   : to the TMDS encoders, FETCH_LEAD cycles behind the request
// Modports: master = generator side (drives everything), slave = consumer side.
interface video_timing_720p_if;
  import hdmi_720p_timing_pkg::*;

  logic       requestValid;
  x_t         requestX;
  y_t         requestY;
  logic       frameStart;
  logic       lineStart;
  logic       blank;
  logic [1:0] sync;

  modport master (
    output requestValid, requestX, requestY, frameStart, lineStart, blank, sync
  );

  modport slave (
    input requestValid, requestX, requestY, frameStart, lineStart, blank, sync
  );

endinterface

// File: rtl/video_timing_720p_delay_line.sv
// video_delay_line: fixed-latency shift register with a synchronous reset value.
// Ports:
//   clock : clock
//   reset : synchronous active-high; loads RESET_VALUE into every stage
//   din   : WIDTH-bit input
//   dout  : din delayed by exactly DEPTH cycles (DEPTH >= 1)
module video_delay_line #(
  parameter int unsigned          WIDTH       = 3,
  parameter int unsigned          DEPTH       = 2,
  parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_reg [DEPTH];

  // Every stage is cleared on reset so nothing captured before the reset
  // can reach the output afterwards.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        stage_reg[i] <= RESET_VALUE;
      end
    end else begin
      stage_reg[0] <= din;
      for (int i = 1; i < int'(DEPTH); i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
    end
  end

  assign dout = stage_reg[DEPTH-1];

endmodule

// File: rtl/video_timing_720p.sv
// video_timing_720p: raster timing generator for the 720p60 HDMI path.
// Pixel-fetch coordinates are issued FETCH_LEAD cycles ahead of the matching
// blank/sync so the pixel source has that long to return data.
// Ports:
//   clock  : pixel clock (74.25 MHz)
//   reset  : synchronous, active-high; restarts timing at (0,0)
//   timing : video_timing_720p_if.master (request, frame/line pulses, blank, sync)
module video_timing_720p
  import hdmi_720p_timing_pkg::X_W, hdmi_720p_timing_pkg::Y_W,
         hdmi_720p_timing_pkg::HSYNC, hdmi_720p_timing_pkg::VSYNC,
         hdmi_720p_timing_pkg::sync_idle;
#(
  parameter int H_ACTIVE         = hdmi_720p_timing_pkg::H_ACTIVE,
  parameter int H_FP             = hdmi_720p_timing_pkg::H_FP,
  parameter int H_SYNC           = hdmi_720p_timing_pkg::H_SYNC,
  parameter int H_BP             = hdmi_720p_timing_pkg::H_BP,
  parameter int V_ACTIVE         = hdmi_720p_timing_pkg::V_ACTIVE,
  parameter int V_FP             = hdmi_720p_timing_pkg::V_FP,
  parameter int V_SYNC           = hdmi_720p_timing_pkg::V_SYNC,
  parameter int V_BP             = hdmi_720p_timing_pkg::V_BP,
  parameter bit SYNC_ACTIVE_HIGH = 1'b1,
  parameter int FETCH_LEAD       = 2   // must be >= 1
) (
  input  logic                       clock,
  input  logic                       reset,
  video_timing_720p_if.master        timing
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [X_W-1:0] H_LAST     = X_W'(H_TOTAL - 1);
  localparam logic [X_W-1:0] H_ACT_END  = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0] HS_BEGIN   = X_W'(H_ACTIVE + H_FP);
  localparam logic [X_W-1:0] HS_END     = X_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [Y_W-1:0] V_LAST     = Y_W'(V_TOTAL - 1);
  localparam logic [Y_W-1:0] V_ACT_END  = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0] VS_BEGIN   = Y_W'(V_ACTIVE + V_FP);
  localparam logic [Y_W-1:0] VS_END     = Y_W'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic [1:0] SYNC_IDLE = sync_idle(SYNC_ACTIVE_HIGH);

  // ---------------------------------------------------------------- counters
  logic [X_W-1:0] h_count_reg;
  logic [Y_W-1:0] v_count_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      h_count_reg <= '0;
      v_count_reg <= '0;
    end else if (h_count_reg == H_LAST) begin
      h_count_reg <= '0;
      v_count_reg <= (v_count_reg == V_LAST) ? '0 : v_count_reg + 1'b1;
    end else begin
      h_count_reg <= h_count_reg + 1'b1;
    end
  end

  // ------------------------------------------------------ decode on counters
  logic       pixel_active;
  logic [1:0] sync_on;

  always_comb begin
    pixel_active   = (h_count_reg < H_ACT_END) && (v_count_reg < V_ACT_END);
    sync_on        = 2'b00;
    sync_on[HSYNC] = (h_count_reg >= HS_BEGIN) && (h_count_reg < HS_END);
    // vsync spans whole lines, so only the line counter matters.
    sync_on[VSYNC] = (v_count_reg >= VS_BEGIN) && (v_count_reg < VS_END);
  end

  // ----------------------------------------------------------- request stage
  logic           request_valid_reg;
  logic [X_W-1:0] request_x_reg;
  logic [Y_W-1:0] request_y_reg;
  logic           frame_start_reg;
  logic           line_start_reg;
  logic [1:0]     sync_req_reg;   // sync levels aligned with the request stage

  always_ff @(posedge clock) begin
    if (reset) begin
      request_valid_reg <= 1'b0;
      request_x_reg     <= '0;
      request_y_reg     <= '0;
      frame_start_reg   <= 1'b0;
      line_start_reg    <= 1'b0;
      sync_req_reg      <= SYNC_IDLE;
    end else begin
      request_valid_reg <= pixel_active;
      request_x_reg     <= pixel_active ? h_count_reg : '0;
      request_y_reg     <= pixel_active ? v_count_reg : '0;
      frame_start_reg   <= pixel_active && (h_count_reg == '0) && (v_count_reg == '0);
      line_start_reg    <= pixel_active && (h_count_reg == '0);
      // An asserted bit is the inverse of its idle level.
      sync_req_reg      <= sync_on ^ SYNC_IDLE;
    end
  end

  // ------------------------------------------------------------ output stage
  // Bundle layout: [0] = blank, [2:1] = sync. Reset value is a control period
  // with both syncs inactive, so no stale active pixel escapes a reset.
  logic [2:0] bundle_in;
  logic [2:0] bundle_out;

  assign bundle_in = {sync_req_reg, ~request_valid_reg};

  video_delay_line #(
    .WIDTH       (3),
    .DEPTH       (FETCH_LEAD),
    .RESET_VALUE ({SYNC_IDLE, 1'b1})
  ) u_delay (
    .clock (clock),
    .reset (reset),
    .din   (bundle_in),
    .dout  (bundle_out)
  );

  assign timing.requestValid = request_valid_reg;
  assign timing.requestX     = request_x_reg;
  assign timing.requestY     = request_y_reg;
  assign timing.frameStart   = frame_start_reg;
  assign timing.lineStart    = line_start_reg;
  assign timing.blank        = bundle_out[0];
  assign timing.sync         = bundle_out[2:1];

endmodule
